// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the streaming UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // Parity bit from the XOR-reduction of the data word and the parity type.
  function automatic logic parity_bit(input logic data_xor, input logic typ);
    logic r;
    case (typ)
      PAR_EVEN: r = data_xor;
      PAR_ODD:  r = ~data_xor;
      default:  r = data_xor;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Purpose: generic synchronous FIFO; pointers carry one extra wrap bit for full/empty.
// Latency: a pushed word is visible at head_data one cycle after the push edge (no bypass).
// Backpressure: caller must not push when full nor pop when empty.
//
// Ports: CLK/RST clock and async active-low reset; push/push_data write side;
// pop/head_data read side; level = words held; full/empty status.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only ever read between the pointers.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr[AW-1:0]];
  assign level     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  // Same slot index but different lap bit means the writer is a full lap ahead.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_stream.sv
// Purpose: UART transmitter with baud divider, TX FIFO, optional parity, 1/2 stop bits.
// Latency: word accepted at edge N into an idle empty block -> start bit driven after edge N+1.
// Backpressure: in_ready low while the FIFO is full (even in a pop cycle); frames run back-to-back.
//
// Ports: CLK/RST clock and async active-low reset; baud_div cycles per bit (0 acts as 1);
// in_data/in_valid/in_ready word input; par_en/par_typ/stop2 frame format, sampled at frame start;
// tx_out registered serial line (idle high); busy frame active or FIFO non-empty; fifo_level.
module uart_tx_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          par_en,
  input  logic                          par_typ,
  input  logic                          stop2,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import uart_pkg::*;

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  uart_tx_state_t        state, state_n;
  logic [DIV_WIDTH-1:0]  div_l;
  logic [DIV_WIDTH-1:0]  div_cnt, div_cnt_n;
  logic [DIV_WIDTH-1:0]  div_eff;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  par_bit;
  logic                  par_en_l;
  logic                  stop2_l;
  logic                  tx_q, tx_n;
  logic                  load;
  logic                  bit_done;

  logic                  fifo_push;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (load),
    .head_data (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign div_eff  = (div_l == '0) ? DIV_WIDTH'(1) : div_l;
  assign bit_done = (div_cnt == div_eff - DIV_WIDTH'(1));

  // tx_n is the line value for the state being entered, so tx_out is a flop
  // yet changes on the same edge as the state.
  always_comb begin
    state_n   = state;
    div_cnt_n = bit_done ? '0 : div_cnt + DIV_WIDTH'(1);
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    tx_n      = tx_q;
    load      = 1'b0;

    case (state)
      ST_IDLE: begin
        div_cnt_n = '0;
        tx_n      = 1'b1;
        if (!fifo_empty) begin
          load    = 1'b1;
          state_n = ST_START;
          tx_n    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
          tx_n      = shreg[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_n = '0;
            if (par_en_l) begin
              state_n = ST_PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = ST_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + CW'(1);
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_n   = ST_STOP;
          bit_cnt_n = '0;
          tx_n      = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if ((bit_cnt == '0) && (stop2_l == STOP_TWO)) begin
            bit_cnt_n = CW'(1);
            tx_n      = 1'b1;
          end else if (!fifo_empty) begin
            // Chain straight into the next start bit with no idle cycle.
            load    = 1'b1;
            state_n = ST_START;
            tx_n    = 1'b0;
          end else begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
      end
    endcase

    if (load) shreg_n = fifo_head;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      div_cnt <= div_cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      tx_q    <= tx_n;
    end
  end

  // Frame format is frozen at pop so mid-frame input changes only affect the next frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_l    <= '0;
      par_en_l <= 1'b0;
      stop2_l  <= STOP_ONE;
      par_bit  <= 1'b0;
    end else if (load) begin
      div_l    <= baud_div;
      par_en_l <= par_en;
      stop2_l  <= stop2;
      par_bit  <= parity_bit(^fifo_head, par_typ);
    end
  end

  assign tx_out = tx_q;
  assign busy   = (state != ST_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_stream.sv
module tb_uart_tx_stream;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 16;

  logic            CLK = 1'b0;
  logic            RST;
  logic [DIVW-1:0] baud_div;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic            par_en;
  logic            par_typ;
  logic            stop2;
  logic            tx_out;
  logic            busy;
  logic [2:0]      fifo_level;

  always #5 CLK = ~CLK;

  uart_tx_stream #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .baud_div   (baud_div),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .stop2      (stop2),
    .tx_out     (tx_out),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         par_en;
    bit         typ;
    bit         par;    // expected parity bit on the line
    bit         stop2;
    bit         b2b;    // frame must start with no idle cycle after the previous one
    int         len;    // frame length in CLK cycles
  } frame_t;

  int     tests = 0;
  int     fails = 0;
  int     n_pushed = 0;
  int     frames_done = 0;
  frame_t sb[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic frame_t mk(input logic [7:0] d, input int div, input bit pe,
                                input bit pt, input bit s2, input bit b2b);
    frame_t f;
    f.data   = d;
    f.div    = div;
    f.par_en = pe;
    f.typ    = pt;
    f.par    = (^d) ^ pt;
    f.stop2  = s2;
    f.b2b    = b2b;
    f.len    = (1 + 8 + int'(pe) + 1 + int'(s2)) * ((div == 0) ? 1 : div);
    return f;
  endfunction

  task automatic set_cfg(input frame_t f);
    baud_div = DIVW'(f.div);
    par_en   = f.par_en;
    par_typ  = f.typ;
    stop2    = f.stop2;
  endtask

  // Returns just after the edge on which the word was accepted.
  task automatic push_frame(input frame_t f);
    int w;
    in_data  = f.data;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 500) begin
      tick();
      w++;
    end
    if (w >= 500) chk("push_timeout", 32'(in_ready), 32'd1);
    sb.push_back(f);
    n_pushed++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int n);
    int bad;
    n   = 0;
    bad = 0;
    while (busy && n < bound) begin
      if (in_ready !== (fifo_level != 3'(DEPTH))) bad++;
      n++;
      tick();
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    chk("ready_vs_level", 32'(bad), 32'd0);
  endtask

  // Line monitor: decodes frames on tx_out and checks each bit against the scoreboard.
  bit     mon_en = 1'b0;
  bit     active = 1'b0;
  frame_t cur;
  bit     bits [16];
  int     nbits, bidx, cyc, d, gap;
  bit     bad, badv;

  always @(negedge CLK) begin
    if (!mon_en) begin
      active = 1'b0;
      gap    = 0;
    end else begin
      if (!active) begin
        if (tx_out === 1'b0) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: tx_out got 0 expected 1 (nothing queued)");
          end else begin
            cur     = sb.pop_front();
            bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) bits[1+i] = cur.data[i];
            nbits = 9;
            if (cur.par_en) begin bits[nbits] = cur.par; nbits++; end
            bits[nbits] = 1'b1; nbits++;
            if (cur.stop2) begin bits[nbits] = 1'b1; nbits++; end
            d = (cur.div == 0) ? 1 : cur.div;
            if (cur.b2b) chk("frame_gap", 32'(gap), 32'd0);
            active = 1'b1;
            bidx   = 0;
            cyc    = 0;
            bad    = 1'b0;
          end
        end else begin
          gap++;
        end
      end
      if (active) begin
        if (tx_out !== bits[bidx] && !bad) begin
          bad  = 1'b1;
          badv = tx_out;
        end
        cyc++;
        if (cyc == d) begin
          tests++;
          if (bad) begin
            fails++;
            $display("FAIL frame_bit: data %0h bit %0d got %b expected %b",
                     cur.data, bidx, badv, bits[bidx]);
          end
          bidx++;
          cyc = 0;
          bad = 1'b0;
          if (bidx == nbits) begin
            active = 1'b0;
            gap    = 0;
            frames_done++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time got limit expected finish");
    $fatal(1);
  end

  frame_t tbl [6];

  initial begin
    int n, bad;
    frame_t f;

    // data, div, par_en, typ, par (hand-derived), stop2, b2b, len
    tbl[0] = '{8'hA5, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 44};
    tbl[1] = '{8'h01, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 48};
    tbl[2] = '{8'h3C, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11};
    tbl[3] = '{8'hFF, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 33};
    tbl[4] = '{8'h07, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24};
    tbl[5] = '{8'h00, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 55};

    in_data  = '0;
    in_valid = 1'b0;
    baud_div = DIVW'(4);
    par_en   = 1'b0;
    par_typ  = 1'b0;
    stop2    = 1'b0;
    RST      = 1'b1;
    #2 RST   = 1'b0;
    #2;
    chk("rst_tx_out", 32'(tx_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    mon_en = 1'b1;
    tick();

    // Single frames from the table: no bypass, start-bit latency, exact length.
    for (int i = 0; i < 6; i++) begin
      set_cfg(tbl[i]);
      push_frame(tbl[i]);
      chk($sformatf("no_bypass_level[%0d]", i), 32'(fifo_level), 32'd1);
      chk($sformatf("no_bypass_tx[%0d]", i), 32'(tx_out), 32'd1);
      chk($sformatf("busy_on_push[%0d]", i), 32'(busy), 32'd1);
      tick();
      chk($sformatf("start_latency[%0d]", i), 32'(tx_out), 32'd0);
      wait_idle(2000, n);
      chk($sformatf("frame_len[%0d]", i), 32'(n), 32'(tbl[i].len));
    end

    // Back-to-back: five words fill the FIFO, frames chain with no gap.
    f = mk(8'h00, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(f);
    for (int k = 0; k < 5; k++) push_frame(mk(8'($urandom), 2, 1'b1, 1'b0, 1'b0, k != 0));
    chk("b2b_full_level", 32'(fifo_level), 32'd4);
    chk("b2b_full_ready", 32'(in_ready), 32'd0);
    wait_idle(2000, n);

    // Format change mid-frame only affects the following frame.
    set_cfg(mk(8'h00, 4, 1'b1, 1'b0, 1'b0, 1'b0));
    push_frame(mk(8'h5A, 4, 1'b1, 1'b0, 1'b0, 1'b0));
    push_frame(mk(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1));
    repeat (10) tick();
    baud_div = DIVW'(8);
    par_en   = 1'b0;
    wait_idle(2000, n);
    chk("midcfg_len", 32'(n), 32'd114);

    // Reset mid-DATA with two words queued.
    set_cfg(mk(8'h00, 4, 1'b1, 1'b0, 1'b0, 1'b0));
    push_frame(mk(8'h00, 4, 1'b1, 1'b0, 1'b0, 1'b0));
    push_frame(mk(8'h11, 4, 1'b1, 1'b0, 1'b0, 1'b1));
    push_frame(mk(8'h22, 4, 1'b1, 1'b0, 1'b0, 1'b1));
    repeat (8) tick();
    chk("pre_rst_level", 32'(fifo_level), 32'd2);
    chk("pre_rst_tx", 32'(tx_out), 32'd0);
    mon_en = 1'b0;
    sb.delete();
    n_pushed -= 3;
    #2 RST = 1'b0;
    #1;
    chk("midrst_tx_out", 32'(tx_out), 32'd1);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    #1 mon_en = 1'b1;
    bad = 0;
    repeat (60) begin
      tick();
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);

    f = mk(8'h96, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    set_cfg(f);
    push_frame(f);
    wait_idle(2000, n);
    chk("post_rst_len", 32'(n), 32'(f.len + 1));

    repeat (3) tick();
    chk("frames_done", 32'(frames_done), 32'(n_pushed));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
